// File: rtl/home_control_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : home_control_fsm_if
//  Purpose  : Bundles the command, handshake and status signals exchanged
//             between home_control_fsm and its surroundings (pushbutton and
//             switch inputs, VGA draw/clear datapath, room registers, audio
//             message player).
//  Revision : 1.0  - initial release
//
//  Modports
//    master : the control FSM (reads commands/handshakes, drives controls)
//    slave  : the environment (drives commands/handshakes, reads controls)
//
//  Signals
//    clear, loadinputs, room_sel[NUM_ROOMS], alllocked, keyboardin, audin,
//    countDone, audio_ack                                  -> into the FSM
//    room_enable[NUM_ROOMS], selsw[ROOM_W], selonoff, selfunct[2],
//    loadenable, clearinitsignal, audio_req, room_light[NUM_ROOMS],
//    room_door[NUM_ROOMS], busy, err_timeout               -> out of the FSM
// ============================================================================
interface home_control_fsm_if #(
   parameter int NUM_ROOMS = 5,
   parameter int ROOM_W    = $clog2(NUM_ROOMS)
) ();
   logic                 clear;
   logic                 loadinputs;
   logic [NUM_ROOMS-1:0] room_sel;
   logic                 alllocked;
   logic                 keyboardin;
   logic                 audin;
   logic                 countDone;
   logic                 audio_ack;

   logic [NUM_ROOMS-1:0] room_enable;
   logic [ROOM_W-1:0]    selsw;
   logic                 selonoff;
   logic [1:0]           selfunct;
   logic                 loadenable;
   logic                 clearinitsignal;
   logic                 audio_req;
   logic [NUM_ROOMS-1:0] room_light;
   logic [NUM_ROOMS-1:0] room_door;
   logic                 busy;
   logic                 err_timeout;

   modport master (
      input  clear, loadinputs, room_sel, alllocked, keyboardin, audin,
             countDone, audio_ack,
      output room_enable, selsw, selonoff, selfunct, loadenable,
             clearinitsignal, audio_req, room_light, room_door, busy,
             err_timeout
   );

   modport slave (
      output clear, loadinputs, room_sel, alllocked, keyboardin, audin,
             countDone, audio_ack,
      input  room_enable, selsw, selonoff, selfunct, loadenable,
             clearinitsignal, audio_req, room_light, room_door, busy,
             err_timeout
   );
endinterface
`default_nettype wire

// File: rtl/home_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : home_control_fsm
//  Purpose  : Control FSM for the home-simulation system. Arbitrates a
//             pushbutton-loaded switch/keyboard/audio command over NUM_ROOMS
//             rooms, sequences the VGA draw/clear datapath (countDone), the
//             room registers and the audio player (audio_req/audio_ack), and
//             keeps per-room light/door status.
//  Revision : 1.0  - initial release
//
//  Ports
//    clock : system clock, rising edge
//    reset : synchronous, active-high
//    bus   : home_control_fsm_if.master (all command/handshake/status lines)
//
//  Optional feature
//    HOME_CTRL_TIMEOUT_EN : when defined, a watchdog aborts DRAW/CLEAR after
//                           TIMEOUT_CYCLES cycles and pulses err_timeout.
//                           Undefined: err_timeout is 0 and DRAW/CLEAR wait
//                           indefinitely.
// ============================================================================
module home_control_fsm #(
   parameter int NUM_ROOMS      = 5,
   parameter int ROOM_W         = $clog2(NUM_ROOMS),
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  wire                      clock,
   input  wire                      reset,
   home_control_fsm_if.master       bus
);

   // ------------------------------------------------------------------------
   // Parameter sanity
   // ------------------------------------------------------------------------
   generate
      if (NUM_ROOMS < 2 || NUM_ROOMS > 16) begin : g_bad_num_rooms
         $error("home_control_fsm: NUM_ROOMS must be 2..16");
      end
      if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
         $error("home_control_fsm: TIMEOUT_CYCLES must be at least 2");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [2:0] c_ST_IDLE    = 3'd0;
   localparam logic [2:0] c_ST_ARMED   = 3'd1;
   localparam logic [2:0] c_ST_DRAW    = 3'd2;
   localparam logic [2:0] c_ST_LOCKALL = 3'd3;
   localparam logic [2:0] c_ST_AUDIO   = 3'd4;
   localparam logic [2:0] c_ST_CLEAR   = 3'd5;

   localparam logic [1:0] c_FN_LIGHT   = 2'b00;
   localparam logic [1:0] c_FN_DOOR    = 2'b10;
   localparam logic [1:0] c_FN_ALLLOCK = 2'b01;

   localparam logic [NUM_ROOMS-1:0] c_ONE_ROOM = NUM_ROOMS'(1);

   logic [2:0]           r_state;
   logic [2:0]           w_state_next;

   // Latched command
   logic [ROOM_W-1:0]    r_cmd_room;
   logic                 r_cmd_fn;
   logic                 r_cmd_on;
   logic                 r_cmd_lock;   // 1: current command came via LOCKALL

   // Status
   logic [NUM_ROOMS-1:0] r_room_light;
   logic [NUM_ROOMS-1:0] r_room_door;
   logic                 r_err_timeout;

   // Room arbitration
   logic [ROOM_W-1:0]    w_sel_idx;
   logic [NUM_ROOMS-1:0] w_sel_onehot;
   logic                 w_any_room;

   logic                 w_tmo_hit;

   // Lowest set bit wins: isolate it with the two's-complement trick, and
   // scan downwards so the last assignment is the lowest index.
   assign w_any_room   = |bus.room_sel;
   assign w_sel_onehot = bus.room_sel & (~bus.room_sel + c_ONE_ROOM);

   always_comb begin
      w_sel_idx = '0;
      for (int i = NUM_ROOMS - 1; i >= 0; i--) begin
         if (bus.room_sel[i]) begin
            w_sel_idx = ROOM_W'(i);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Draw/clear watchdog
   // ------------------------------------------------------------------------
`ifdef HOME_CTRL_TIMEOUT_EN
   localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [c_CNT_W-1:0] r_tmo_cnt;
   logic               w_timed;

   assign w_timed = (r_state == c_ST_DRAW) || (r_state == c_ST_CLEAR);

   // In CLEAR a countDone only counts once clear has dropped; since a live
   // clear already takes priority over the watchdog, testing !clear here
   // covers both DRAW and CLEAR qualification.
   always_comb begin
      w_tmo_hit = w_timed && (r_tmo_cnt == c_CNT_LAST)
                  && !bus.countDone && !bus.clear;
   end

   // Restart on every state change and while clear is held, so each visit
   // to DRAW/CLEAR (after clear is released) gets the full budget.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_tmo_cnt <= '0;
      end else if (bus.clear || (w_state_next != r_state)) begin
         r_tmo_cnt <= '0;
      end else if (w_timed) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end
`else
   assign w_tmo_hit = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic (priority: clear > watchdog > normal flow)
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         c_ST_IDLE: begin
            if (bus.loadinputs) w_state_next = c_ST_ARMED;
         end
         c_ST_ARMED: begin
            if (!bus.loadinputs) begin
               if (w_any_room)         w_state_next = c_ST_DRAW;
               else if (bus.alllocked) w_state_next = c_ST_LOCKALL;
               else                    w_state_next = c_ST_IDLE;
            end
         end
         c_ST_DRAW: begin
            if (bus.countDone) w_state_next = c_ST_AUDIO;
         end
         c_ST_LOCKALL: begin
            w_state_next = c_ST_AUDIO;
         end
         c_ST_AUDIO: begin
            if (bus.audio_ack) w_state_next = c_ST_IDLE;
         end
         c_ST_CLEAR: begin
            if (bus.countDone) w_state_next = c_ST_IDLE;
         end
         default: begin
            w_state_next = c_ST_IDLE;
         end
      endcase

      if (w_tmo_hit) w_state_next = c_ST_IDLE;
      if (bus.clear) w_state_next = c_ST_CLEAR;
   end

   // ------------------------------------------------------------------------
   // Command latch, status registers and timeout pulse
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cmd_room    <= '0;
         r_cmd_fn      <= 1'b0;
         r_cmd_on      <= 1'b0;
         r_cmd_lock    <= 1'b0;
         r_room_light  <= '0;
         r_room_door   <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         r_err_timeout <= w_tmo_hit;

         // Status is written on the edge that enters DRAW, so it is already
         // visible during the first DRAW cycle.
         if (r_state == c_ST_ARMED && w_state_next == c_ST_DRAW) begin
            r_cmd_room <= w_sel_idx;
            r_cmd_fn   <= bus.keyboardin;
            r_cmd_on   <= bus.audin;
            r_cmd_lock <= 1'b0;
            if (bus.keyboardin) begin
               r_room_light <= (r_room_light & ~w_sel_onehot)
                               | (w_sel_onehot & {NUM_ROOMS{bus.audin}});
            end else begin
               r_room_door  <= (r_room_door & ~w_sel_onehot)
                               | (w_sel_onehot & {NUM_ROOMS{bus.audin}});
            end
         end

         if (r_state == c_ST_ARMED && w_state_next == c_ST_LOCKALL) begin
            r_cmd_lock <= 1'b1;
         end

         // Doors close on the edge leaving LOCKALL; a clear landing on that
         // edge pre-empts the lock.
         if (r_state == c_ST_LOCKALL && w_state_next == c_ST_AUDIO) begin
            r_room_door <= '0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------------
   logic [NUM_ROOMS-1:0] w_room_enable;
   logic [ROOM_W-1:0]    w_selsw;
   logic                 w_selonoff;
   logic [1:0]           w_selfunct;
   logic                 w_loadenable;
   logic                 w_clearinit;
   logic                 w_audio_req;
   logic [1:0]           w_cmd_funct;

   assign w_cmd_funct = r_cmd_fn ? c_FN_LIGHT : c_FN_DOOR;

   always_comb begin
      w_room_enable = '0;
      w_selsw       = '0;
      w_selonoff    = 1'b0;
      w_selfunct    = 2'b00;
      w_loadenable  = 1'b0;
      w_clearinit   = 1'b0;
      w_audio_req   = 1'b0;
      unique case (r_state)
         c_ST_ARMED: begin
            w_loadenable = 1'b1;
            w_selsw      = w_sel_idx;   // live switch preview
         end
         c_ST_DRAW: begin
            w_room_enable = c_ONE_ROOM << r_cmd_room;
            w_selsw       = r_cmd_room;
            w_selonoff    = r_cmd_on;
            w_selfunct    = w_cmd_funct;
         end
         c_ST_LOCKALL: begin
            w_selfunct = c_FN_ALLLOCK;
         end
         c_ST_AUDIO: begin
            w_audio_req = 1'b1;
            if (r_cmd_lock) begin
               w_selfunct = c_FN_ALLLOCK;
            end else begin
               w_selonoff = r_cmd_on;
               w_selfunct = w_cmd_funct;
            end
         end
         c_ST_CLEAR: begin
            w_clearinit = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.room_enable     = w_room_enable;
   assign bus.selsw           = w_selsw;
   assign bus.selonoff        = w_selonoff;
   assign bus.selfunct        = w_selfunct;
   assign bus.loadenable      = w_loadenable;
   assign bus.clearinitsignal = w_clearinit;
   assign bus.audio_req       = w_audio_req;
   assign bus.room_light      = r_room_light;
   assign bus.room_door       = r_room_door;
   assign bus.busy            = (r_state != c_ST_IDLE);
   assign bus.err_timeout     = r_err_timeout;

endmodule
`default_nettype wire
